// File: rtl/jcr_int_ctrl.sv
// Interrupt controller for the jacaranda-8 core: edge-detects sources, latches pending,
// arbitrates by fixed priority and issues a one-cycle request held off until iret.
module jcr_int_ctrl #(
  parameter int         NSRC       = 4,
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         VEC_STRIDE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            iret,
  input  logic [7:0]      bus_addr,
  input  logic [7:0]      bus_w_data,
  input  logic            bus_w_en,
  output logic [7:0]      bus_r_data,
  output logic            bus_sel,
  output logic            int_req,
  output logic [7:0]      int_en,
  output logic [7:0]      int_vec
);

  // state   | meaning
  // IDLE    | no interrupt in flight; arbitrate eligible pending sources
  // REQ     | int_req pulse cycle; iret ignored
  // SERVICE | core is servicing active_id; wait for iret
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  localparam logic [7:0] EN_MASK = 8'((1 << (NSRC + 1)) - 1);
  localparam logic [7:0] STRIDE  = 8'(VEC_STRIDE);

  state_t          state_q, state_d;
  logic [7:0]      int_en_q, int_en_d;
  logic [7:0]      vec_base_q, vec_base_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] irq_prev_q, irq_prev_d;
  logic [2:0]      active_id_q, active_id_d;
  logic            int_req_q, int_req_d;
  logic [7:0]      int_vec_q, int_vec_d;

  logic [7:0]      off;
  logic            wr_en;
  logic [NSRC-1:0] rise, eligible, w1c, fsm_clr;
  logic [2:0]      winner;
  logic            in_service;

  assign off        = bus_addr - BASE_ADDR;
  assign bus_sel    = (off < 8'd4);
  assign wr_en      = bus_w_en & bus_sel;
  assign rise       = irq_src & ~irq_prev_q;
  assign eligible   = pending_q & int_en_q[NSRC:1] & {NSRC{int_en_q[0]}};
  assign in_service = (state_q != ST_IDLE);

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    int_req_d   = 1'b0;
    active_id_d = active_id_q;
    int_vec_d   = int_vec_q;
    fsm_clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d     = ST_REQ;
          int_req_d   = 1'b1;
          active_id_d = winner;
          int_vec_d   = vec_base_q + {5'd0, winner} * STRIDE;
          fsm_clr     = NSRC'(1) << winner;
        end
      end
      ST_REQ:     state_d = ST_SERVICE;
      ST_SERVICE: if (iret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A fresh edge outranks both the arbitration clear and a write-1-to-clear.
  always_comb begin
    w1c        = (wr_en && off[1:0] == 2'd2) ? bus_w_data[NSRC-1:0] : '0;
    pending_d  = (pending_q & ~(w1c | fsm_clr)) | rise;
    irq_prev_d = irq_src;
    int_en_d   = (wr_en && off[1:0] == 2'd0) ? (bus_w_data & EN_MASK) : int_en_q;
    vec_base_d = (wr_en && off[1:0] == 2'd1) ? bus_w_data : vec_base_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      int_en_q    <= '0;
      vec_base_q  <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      active_id_q <= '0;
      int_req_q   <= 1'b0;
      int_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      int_en_q    <= int_en_d;
      vec_base_q  <= vec_base_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_prev_d;
      active_id_q <= active_id_d;
      int_req_q   <= int_req_d;
      int_vec_q   <= int_vec_d;
    end
  end

  always_comb begin
    bus_r_data = '0;
    if (bus_sel) begin
      case (off[1:0])
        2'd0:    bus_r_data = int_en_q;
        2'd1:    bus_r_data = vec_base_q;
        2'd2:    bus_r_data = 8'(pending_q);
        default: bus_r_data = {4'd0, active_id_q, in_service};
      endcase
    end
  end

  assign int_req = int_req_q;
  assign int_en  = int_en_q;
  assign int_vec = int_vec_q;

endmodule

// File: tb/tb_jcr_int_ctrl.sv
// Bench for jcr_int_ctrl: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural model of the controller.
module tb_jcr_int_ctrl;
  localparam int NSRC = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] irq_src = '0;
  logic            iret = 1'b0;
  logic [7:0]      bus_addr = '0;
  logic [7:0]      bus_w_data = '0;
  logic            bus_w_en = 1'b0;
  logic [7:0]      bus_r_data;
  logic            bus_sel;
  logic            int_req;
  logic [7:0]      int_en;
  logic [7:0]      int_vec;

  int tests = 0;
  int fails = 0;

  jcr_int_ctrl #(.NSRC(NSRC), .BASE_ADDR(8'hF0), .VEC_STRIDE(4)) dut (
    .clock(clock), .reset(reset), .irq_src(irq_src), .iret(iret),
    .bus_addr(bus_addr), .bus_w_data(bus_w_data), .bus_w_en(bus_w_en),
    .bus_r_data(bus_r_data), .bus_sel(bus_sel), .int_req(int_req),
    .int_en(int_en), .int_vec(int_vec)
  );

  always #5 clock = ~clock;

  // behavioural model
  int m_en, m_vb, m_vec, m_act;
  bit m_req, m_serv;
  bit m_pend[NSRC];
  bit m_prev[NSRC];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [7:0] a);
    return (a >= 8'hF0) && (a <= 8'hF3);
  endfunction

  task automatic model_step();
    int win;
    int old_en;
    if (!reset) begin
      m_en = 0; m_vb = 0; m_vec = 0; m_act = 0; m_req = 0; m_serv = 0;
      for (int i = 0; i < NSRC; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
    end else begin
      old_en = m_en;
      win = -1;
      for (int i = 0; i < NSRC; i++)
        if (win < 0 && m_pend[i] && old_en[i+1] && old_en[0]) win = i;
      for (int i = 0; i < NSRC; i++) begin
        if (bus_w_en && bus_addr == 8'hF2 && bus_w_data[i]) m_pend[i] = 0;
        if (!m_serv && i == win) m_pend[i] = 0;
        if (irq_src[i] && !m_prev[i]) m_pend[i] = 1;
        m_prev[i] = irq_src[i];
      end
      if (!m_serv && win >= 0) begin
        m_req = 1; m_serv = 1; m_act = win;
        m_vec = (m_vb + win * 4) % 256;
      end else begin
        if (m_serv && !m_req && iret) m_serv = 0;
        m_req = 0;
      end
      if (bus_w_en && bus_addr == 8'hF0) m_en = int'(bus_w_data) & ((1 << (NSRC + 1)) - 1);
      if (bus_w_en && bus_addr == 8'hF1) m_vb = int'(bus_w_data);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    int p = 0;
    for (int i = 0; i < NSRC; i++) if (m_pend[i]) p += (1 << i);
    case (a)
      8'hF0:   return 8'(m_en);
      8'hF1:   return 8'(m_vb);
      8'hF2:   return 8'(p);
      8'hF3:   return 8'(m_act * 2 + int'(m_serv));
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clock) begin
    model_step();
    #2;
    chk("int_req", {7'd0, int_req}, {7'd0, m_req});
    chk("int_en", int_en, 8'(m_en));
    chk("int_vec", int_vec, 8'(m_vec));
    chk("bus_sel", {7'd0, bus_sel}, {7'd0, in_window(bus_addr)});
    chk("bus_r_data", bus_r_data, model_rd(bus_addr));
  end

  task automatic cyc();
    @(posedge clock);
    #3;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a; bus_w_data = d; bus_w_en = 1'b1;
    cyc();
    bus_w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    #1;
    d = bus_r_data;
  endtask

  task automatic do_iret();
    iret = 1'b1; cyc(); iret = 1'b0; cyc();
  endtask

  logic [7:0] r;

  initial begin
    reset = 1'b0;
    cyc(); cyc();
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_int_vec", int_vec, 8'h00);
    reset = 1'b1;

    // single source, latency and status
    wr(8'hF0, 8'h03); wr(8'hF1, 8'h40);
    bus_addr = 8'hF3; irq_src = 4'b0001;
    cyc();
    chk("t1_no_req_yet", {7'd0, int_req}, 8'h00);
    cyc();
    chk("t1_req", {7'd0, int_req}, 8'h01);
    chk("t1_vec", int_vec, 8'h40);
    chk("t1_model_vec", 8'(m_vec), 8'h40);
    rd(8'hF3, r); chk("t1_status", r, 8'h01);
    cyc();
    chk("t1_req_one_cycle", {7'd0, int_req}, 8'h00);
    irq_src = '0;
    do_iret();

    // two simultaneous sources, priority then follow-up after iret
    wr(8'hF0, 8'h0F);
    irq_src = 4'b0110;
    cyc(); cyc();
    chk("t2_vec1", int_vec, 8'h44);
    cyc(); cyc();
    iret = 1'b1; cyc(); iret = 1'b0;
    chk("t2_gap", {7'd0, int_req}, 8'h00);
    cyc();
    chk("t2_req2", {7'd0, int_req}, 8'h01);
    chk("t2_vec2", int_vec, 8'h48);
    chk("t2_model_vec2", 8'(m_vec), 8'h48);
    cyc(); do_iret();

    // masked source latches, serviced once unmasked
    irq_src = '0; cyc();
    wr(8'hF0, 8'h01);
    irq_src = 4'b1000;
    cyc(); cyc(); cyc();
    chk("t3_masked_no_req", {7'd0, int_req}, 8'h00);
    rd(8'hF2, r); chk("t3_pending", r, 8'h08);
    wr(8'hF0, 8'h11);
    chk("t3_prewrite_decision", {7'd0, int_req}, 8'h00);
    cyc();
    chk("t3_req", {7'd0, int_req}, 8'h01);
    chk("t3_vec", int_vec, 8'h4C);
    rd(8'hF2, r); chk("t3_pending_clr", r, 8'h00);
    cyc(); do_iret();

    // re-edge while in service, iret in REQ and IDLE ignored
    irq_src = '0; cyc();
    wr(8'hF0, 8'h03);
    irq_src = 4'b0001; cyc(); cyc();
    chk("t4_req1", {7'd0, int_req}, 8'h01);
    irq_src = '0; cyc();
    irq_src = 4'b0001; cyc(); cyc(); cyc();
    chk("t4_held_off", {7'd0, int_req}, 8'h00);
    iret = 1'b1; cyc(); iret = 1'b0;
    chk("t4_gap", {7'd0, int_req}, 8'h00);
    cyc();
    chk("t4_req2", {7'd0, int_req}, 8'h01);
    iret = 1'b1; cyc(); iret = 1'b0;
    rd(8'hF3, r); chk("t4_iret_in_req_ignored", r, 8'h01);
    do_iret();
    rd(8'hF3, r); chk("t4_idle_status", r, 8'h00);
    do_iret(); cyc();
    chk("t4_iret_idle_no_req", {7'd0, int_req}, 8'h00);

    // write-1-to-clear and set-wins
    irq_src = '0; cyc();
    wr(8'hF0, 8'h00);
    irq_src = 4'b0110; cyc();
    rd(8'hF2, r); chk("t5_pend06", r, 8'h06);
    wr(8'hF2, 8'h02);
    rd(8'hF2, r); chk("t5_w1c", r, 8'h04);
    irq_src = 4'b0100; cyc();
    irq_src = 4'b0110; cyc();
    irq_src = 4'b0100; cyc();
    irq_src = 4'b0110;
    wr(8'hF2, 8'h02);
    rd(8'hF2, r); chk("t5_set_wins", r, 8'h06);
    wr(8'hF2, 8'hFF);
    rd(8'hF2, r); chk("t5_clear_all", r, 8'h00);

    // reset during service
    irq_src = '0; cyc();
    wr(8'hF0, 8'h03);
    irq_src = 4'b0001; cyc(); cyc();
    chk("t6_req", {7'd0, int_req}, 8'h01);
    cyc();
    reset = 1'b0; irq_src = '0; cyc();
    chk("t6_req_rst", {7'd0, int_req}, 8'h00);
    chk("t6_vec_rst", int_vec, 8'h00);
    rd(8'hF3, r); chk("t6_status_rst", r, 8'h00);
    rd(8'hF2, r); chk("t6_pend_rst", r, 8'h00);
    rd(8'hF4, r); chk("t6_out_of_window", r, 8'h00);
    chk("t6_sel_out", {7'd0, bus_sel}, 8'h00);
    reset = 1'b1; cyc(); cyc(); cyc();
    chk("t6_no_req_after", {7'd0, int_req}, 8'h00);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 299) != 0);
      irq_src  = irq_src ^ (NSRC'($urandom) & NSRC'($urandom));
      iret     = ($urandom_range(0, 5) == 0);
      bus_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hF0 + $urandom_range(0, 5));
      bus_w_data = 8'($urandom);
      if (bus_addr == 8'hF0) bus_w_data[0] = ($urandom_range(0, 3) != 0);
      bus_w_en = ($urandom_range(0, 3) == 0);
      cyc();
    end
    bus_w_en = 1'b0; iret = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
